mem_access_stage: RTL and testbench

Memory stage of the 16-bit pipelined MIPS, directly upstream of the MEM/WB pipeline register. Holds the data memory and performs a load or store using ALU_Res as the address. Drives the MEM/WB register inputs: WB enable, MemRead, PC, ALU result, load data and destination register. Memory access takes MEM_LAT cycles; the block runs a small FSM that asserts Mem_Stall so the upstream pipeline holds until the access completes.

---
 rtl/mem_access_stage.sv | 165 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: memory stage of the 16-bit pipelined MIPS.
// Holds the data memory, performs loads and stores addressed by ALU_Res, and
// drives the MEM/WB pipeline register inputs. An access lasts MEM_LAT cycles.
// A two-state FSM (IDLE/BUSY) with a 4-bit down-counter raises Mem_Stall for
// the first MEM_LAT-1 cycles of each access.
//
// Optional feature macro: MEM_STALL_STATS_EN
//   When defined, the block adds the output Stall_Count[15:0]. It is a
//   saturating count of cycles with Mem_Stall=1 and is cleared by reset.
module mem_access_stage #(
  parameter int ADDR_W  = 8,  // word-address width; depth is 2**ADDR_W words
  parameter int MEM_LAT = 2   // access latency in cycles, 1..15
) (
  input  logic        Clk,
  input  logic        rst,
  input  logic        WB_EN_in,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [9:0]  PC_in,
  input  logic [15:0] ALU_Res,
  input  logic [15:0] Val_Rm,
  input  logic [3:0]  Dst_in,
  output logic        WB_Enable,
  output logic        MemRead,
  output logic [9:0]  PC,
  output logic [15:0] ALU_Result,
  output logic [15:0] DataMem,
  output logic [3:0]  Dst_Mem,
  output logic        Mem_Stall
`ifdef MEM_STALL_STATS_EN
  ,
  output logic [15:0] Stall_Count
`endif
);

  localparam int DEPTH = 1 << ADDR_W;

  // FSM encoding kept as plain constants for compatibility with older tools.
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  // Multi-cycle accesses go through BUSY; a single-cycle access never leaves IDLE.
  localparam bit         MULTI_CYCLE = (MEM_LAT > 1);
  // Counter value loaded on entry to BUSY: the number of further stall cycles.
  localparam logic [3:0] CNT_INIT    = MULTI_CYCLE ? 4'(MEM_LAT - 2) : 4'd0;

  // Reject an out-of-range latency at elaboration instead of silently
  // truncating it into the 4-bit counter.
  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_latency
    $error("mem_access_stage: MEM_LAT must be within 1..15");
  end

  // ---------------------------------------------------------------------------
  // Storage and addressing
  // ---------------------------------------------------------------------------
  logic [15:0]       mem [DEPTH];
  logic [ADDR_W-1:0] word_idx;
  logic              unused_addr_bits;

  // Byte address to word index: bit 0 is dropped and high bits wrap.
  assign word_idx         = ALU_Res[ADDR_W:1];
  assign unused_addr_bits = ^{ALU_Res[15:ADDR_W+1], ALU_Res[0]};

  // ---------------------------------------------------------------------------
  // Access sequencing
  // ---------------------------------------------------------------------------
  logic [0:0] state;
  logic [0:0] state_nx;
  logic [3:0] cnt;
  logic [3:0] cnt_nx;
  logic       req;
  logic       stall;
  logic       final_cycle;

  assign req = MEM_R_EN | MEM_W_EN;

  // Decode the current cycle (stall / final) and the next FSM state.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned; without that the tool infers a latch.
    state_nx    = state;
    cnt_nx      = cnt;
    stall       = 1'b0;
    final_cycle = 1'b0;

    case (state)
      IDLE: begin
        if (req) begin
          if (MULTI_CYCLE) begin
            stall    = 1'b1;
            state_nx = BUSY;
            cnt_nx   = CNT_INIT;
          end else begin
            final_cycle = 1'b1;
          end
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          final_cycle = 1'b1;
          state_nx    = IDLE;
        end else begin
          stall  = 1'b1;
          cnt_nx = cnt - 4'd1;
        end
      end
    endcase

    // While reset is held nothing stalls and no access completes, so an
    // interrupted store can never commit on the reset edge.
    if (!rst) begin
      stall       = 1'b0;
      final_cycle = 1'b0;
    end
  end

  // FSM state and latency counter; reset aborts any access in flight.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Store commits on the edge that ends the final access cycle.
  always_ff @(posedge Clk) begin
    // NOTE: the memory array has no reset branch; its contents survive reset
    // and it can map onto plain RAM cells.
    if (final_cycle && MEM_W_EN) begin
      mem[word_idx] <= Val_Rm;
    end
  end

  // ---------------------------------------------------------------------------
  // MEM/WB register inputs
  // ---------------------------------------------------------------------------
  // The asynchronous read sees the pre-store word, so a combined load+store
  // returns the old content.
  assign DataMem    = mem[word_idx];
  assign PC         = PC_in;
  assign ALU_Result = ALU_Res;
  assign Dst_Mem    = Dst_in;

  // Stall cycles and reset cycles hand a bubble to MEM/WB.
  assign Mem_Stall  = stall;
  assign WB_Enable  = rst & ~stall & WB_EN_in;
  assign MemRead    = rst & ~stall & MEM_R_EN;

`ifdef MEM_STALL_STATS_EN
  // Saturating count of stalled cycles for performance monitoring.
  always_ff @(posedge Clk) begin
    if (!rst) begin
      Stall_Count <= 16'd0;
    end else if (stall && (Stall_Count != 16'hFFFF)) begin
      Stall_Count <= Stall_Count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage. It instantiates three copies: MEM_LAT=1,
// MEM_LAT=3 and MEM_LAT=4, with ADDR_W=8. Each copy has its own input set and
// they share the clock and reset. Directed vectors use hand-computed
// expectations. Stall_Count is exercised when MEM_STALL_STATS_EN is defined.
module tb_mem_access_stage;

  logic        Clk;
  logic        rst;

  logic        wb_en_in  [3];
  logic        mem_r_en  [3];
  logic        mem_w_en  [3];
  logic [9:0]  pc_in     [3];
  logic [15:0] alu_res   [3];
  logic [15:0] val_rm    [3];
  logic [3:0]  dst_in    [3];

  logic        wb_enable [3];
  logic        mem_read  [3];
  logic [9:0]  pc_out    [3];
  logic [15:0] alu_out   [3];
  logic [15:0] data_mem  [3];
  logic [3:0]  dst_mem   [3];
  logic        mem_stall [3];
`ifdef MEM_STALL_STATS_EN
  logic [15:0] stall_count [3];
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  localparam int D1 = 0;  // MEM_LAT=1
  localparam int D3 = 1;  // MEM_LAT=3
  localparam int D4 = 2;  // MEM_LAT=4

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  mem_access_stage #(.ADDR_W(8), .MEM_LAT(1)) u_lat1 (
    .Clk(Clk), .rst(rst),
    .WB_EN_in(wb_en_in[0]), .MEM_R_EN(mem_r_en[0]), .MEM_W_EN(mem_w_en[0]),
    .PC_in(pc_in[0]), .ALU_Res(alu_res[0]), .Val_Rm(val_rm[0]), .Dst_in(dst_in[0]),
    .WB_Enable(wb_enable[0]), .MemRead(mem_read[0]), .PC(pc_out[0]),
    .ALU_Result(alu_out[0]), .DataMem(data_mem[0]), .Dst_Mem(dst_mem[0]),
    .Mem_Stall(mem_stall[0])
`ifdef MEM_STALL_STATS_EN
    , .Stall_Count(stall_count[0])
`endif
  );

  mem_access_stage #(.ADDR_W(8), .MEM_LAT(3)) u_lat3 (
    .Clk(Clk), .rst(rst),
    .WB_EN_in(wb_en_in[1]), .MEM_R_EN(mem_r_en[1]), .MEM_W_EN(mem_w_en[1]),
    .PC_in(pc_in[1]), .ALU_Res(alu_res[1]), .Val_Rm(val_rm[1]), .Dst_in(dst_in[1]),
    .WB_Enable(wb_enable[1]), .MemRead(mem_read[1]), .PC(pc_out[1]),
    .ALU_Result(alu_out[1]), .DataMem(data_mem[1]), .Dst_Mem(dst_mem[1]),
    .Mem_Stall(mem_stall[1])
`ifdef MEM_STALL_STATS_EN
    , .Stall_Count(stall_count[1])
`endif
  );

  mem_access_stage #(.ADDR_W(8), .MEM_LAT(4)) u_lat4 (
    .Clk(Clk), .rst(rst),
    .WB_EN_in(wb_en_in[2]), .MEM_R_EN(mem_r_en[2]), .MEM_W_EN(mem_w_en[2]),
    .PC_in(pc_in[2]), .ALU_Res(alu_res[2]), .Val_Rm(val_rm[2]), .Dst_in(dst_in[2]),
    .WB_Enable(wb_enable[2]), .MemRead(mem_read[2]), .PC(pc_out[2]),
    .ALU_Result(alu_out[2]), .DataMem(data_mem[2]), .Dst_Mem(dst_mem[2]),
    .Mem_Stall(mem_stall[2])
`ifdef MEM_STALL_STATS_EN
    , .Stall_Count(stall_count[2])
`endif
  );

  // Put one DUT's inputs into a no-request state.
  task automatic idle(input int d);
    wb_en_in[d] = 1'b0;
    mem_r_en[d] = 1'b0;
    mem_w_en[d] = 1'b0;
    pc_in[d]    = 10'd0;
    alu_res[d]  = 16'd0;
    val_rm[d]   = 16'd0;
    dst_in[d]   = 4'd0;
  endtask

  // Hold one access on DUT d until Mem_Stall drops (bounded to 16 cycles).
  // Called just after a rising edge; returns just after the edge that ends the
  // final cycle. Bit c of stall_h/wb_h is Mem_Stall/WB_Enable in cycle c.
  // ncyc stays 0 if the access never completes.
  task automatic run_access(input int d, input logic r, input logic w,
                            input logic [15:0] addr, input logic [15:0] wd,
                            output int ncyc, output logic [15:0] stall_h,
                            output logic [15:0] wb_h, output logic [15:0] rdata,
                            output logic mr);
    ncyc    = 0;
    stall_h = '0;
    wb_h    = '0;
    rdata   = '0;
    mr      = 1'b0;
    wb_en_in[d] = r;
    mem_r_en[d] = r;
    mem_w_en[d] = w;
    pc_in[d]    = addr[9:0];
    alu_res[d]  = addr;
    val_rm[d]   = wd;
    dst_in[d]   = addr[3:0];
    for (int c = 0; c < 16; c++) begin
      @(negedge Clk);
      stall_h[c] = mem_stall[d];
      wb_h[c]    = wb_enable[d];
      if (!mem_stall[d]) begin
        ncyc  = c + 1;
        rdata = data_mem[d];
        mr    = mem_read[d];
        @(posedge Clk);
        #1;
        break;
      end
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    // A pending load during reset must not stall and must produce a bubble.
    wb_en_in[D3] = 1'b1;
    mem_r_en[D3] = 1'b1;
    pc_in[D3]    = 10'h2A5;
    alu_res[D3]  = 16'h0020;
    dst_in[D3]   = 4'd9;
    @(negedge Clk);
    n_cmp++;
    if (mem_stall[D3] !== 1'b0) begin
      n_bad++; $display("FAIL reset_stall: got %b expected 0", mem_stall[D3]);
    end
    n_cmp++;
    if (wb_enable[D3] !== 1'b0) begin
      n_bad++; $display("FAIL reset_wb: got %b expected 0", wb_enable[D3]);
    end
    n_cmp++;
    if (mem_read[D3] !== 1'b0) begin
      n_bad++; $display("FAIL reset_memread: got %b expected 0", mem_read[D3]);
    end
    n_cmp++;
    if (pc_out[D3] !== 10'h2A5) begin
      n_bad++; $display("FAIL reset_pc: got %h expected 2a5", pc_out[D3]);
    end
    n_cmp++;
    if (dst_mem[D3] !== 4'd9) begin
      n_bad++; $display("FAIL reset_dst: got %h expected 9", dst_mem[D3]);
    end
    @(posedge Clk);
    #1;
    rst = 1'b1;
    idle(D1); idle(D3); idle(D4);
    @(posedge Clk);
    #1;
  endtask

  task automatic test_lat1_store_load();
    int n; logic [15:0] sh, wh, rd; logic mr;
    run_access(D1, 1'b0, 1'b1, 16'h0010, 16'hBEEF, n, sh, wh, rd, mr);
    n_cmp++;
    if (n !== 1 || sh !== 16'h0000) begin
      n_bad++; $display("FAIL lat1_store_cycles: got %0d stall %h expected 1 stall 0000", n, sh);
    end
    run_access(D1, 1'b1, 1'b0, 16'h0010, 16'h0000, n, sh, wh, rd, mr);
    n_cmp++;
    if (n !== 1 || sh !== 16'h0000) begin
      n_bad++; $display("FAIL lat1_load_cycles: got %0d stall %h expected 1 stall 0000", n, sh);
    end
    n_cmp++;
    if (rd !== 16'hBEEF) begin
      n_bad++; $display("FAIL lat1_load_data: got %h expected beef", rd);
    end
    n_cmp++;
    if (mr !== 1'b1 || wh !== 16'h0001) begin
      n_bad++; $display("FAIL lat1_load_flags: got memread %b wb %h expected 1 0001", mr, wh);
    end
    idle(D1);
  endtask

  task automatic test_alias();
    int n; logic [15:0] sh, wh, rd; logic mr;
    // 0x0210 -> word 0x108 -> wraps to index 8, same word as 0x0010 / 0x0011.
    run_access(D1, 1'b0, 1'b1, 16'h0210, 16'hCAFE, n, sh, wh, rd, mr);
    run_access(D1, 1'b1, 1'b0, 16'h0010, 16'h0000, n, sh, wh, rd, mr);
    n_cmp++;
    if (rd !== 16'hCAFE) begin
      n_bad++; $display("FAIL alias_wrap: got %h expected cafe", rd);
    end
    run_access(D1, 1'b1, 1'b0, 16'h0011, 16'h0000, n, sh, wh, rd, mr);
    n_cmp++;
    if (rd !== 16'hCAFE) begin
      n_bad++; $display("FAIL alias_bit0: got %h expected cafe", rd);
    end
    idle(D1);
  endtask

  task automatic test_lat3_load();
    int n; logic [15:0] sh, wh, rd; logic mr;
    run_access(D3, 1'b0, 1'b1, 16'h0020, 16'h1234, n, sh, wh, rd, mr);
    n_cmp++;
    if (n !== 3 || sh !== 16'h0003 || wh !== 16'h0000) begin
      n_bad++; $display("FAIL lat3_store_seq: got n=%0d stall %h wb %h expected 3 0003 0000", n, sh, wh);
    end
    run_access(D3, 1'b1, 1'b0, 16'h0020, 16'h0000, n, sh, wh, rd, mr);
    n_cmp++;
    if (n !== 3 || sh !== 16'h0003) begin
      n_bad++; $display("FAIL lat3_load_stall: got n=%0d stall %h expected 3 0003", n, sh);
    end
    n_cmp++;
    if (wh !== 16'h0004) begin
      n_bad++; $display("FAIL lat3_load_wb: got %h expected 0004", wh);
    end
    n_cmp++;
    if (rd !== 16'h1234 || mr !== 1'b1) begin
      n_bad++; $display("FAIL lat3_load_data: got %h memread %b expected 1234 1", rd, mr);
    end
    idle(D3);
  endtask

  task automatic test_back_to_back();
    int n1, n2, t0; logic [15:0] sh1, sh2, wh, rd; logic mr;
    t0 = cyc;
    run_access(D3, 1'b0, 1'b1, 16'h0040, 16'h5A5A, n1, sh1, wh, rd, mr);
    run_access(D3, 1'b1, 1'b0, 16'h0040, 16'h0000, n2, sh2, wh, rd, mr);
    n_cmp++;
    if (sh1 !== 16'h0003 || sh2 !== 16'h0003) begin
      n_bad++; $display("FAIL b2b_stalls: got %h %h expected 0003 0003", sh1, sh2);
    end
    n_cmp++;
    if (cyc - t0 !== 6) begin
      n_bad++; $display("FAIL b2b_total_cycles: got %0d expected 6", cyc - t0);
    end
    n_cmp++;
    if (rd !== 16'h5A5A) begin
      n_bad++; $display("FAIL b2b_data: got %h expected 5a5a", rd);
    end
    idle(D3);
  endtask

  task automatic test_read_write();
    int n; logic [15:0] sh, wh, rd; logic mr;
    // Word at 0x20 holds 0x1234; combined access returns old data, then stores.
    run_access(D3, 1'b1, 1'b1, 16'h0020, 16'h9999, n, sh, wh, rd, mr);
    n_cmp++;
    if (rd !== 16'h1234 || mr !== 1'b1) begin
      n_bad++; $display("FAIL rw_old_data: got %h memread %b expected 1234 1", rd, mr);
    end
    run_access(D3, 1'b1, 1'b0, 16'h0020, 16'h0000, n, sh, wh, rd, mr);
    n_cmp++;
    if (rd !== 16'h9999) begin
      n_bad++; $display("FAIL rw_new_data: got %h expected 9999", rd);
    end
    idle(D3);
  endtask

  task automatic test_passthrough();
    wb_en_in[D3] = 1'b1;
    pc_in[D3]    = 10'h155;
    alu_res[D3]  = 16'h5555;
    dst_in[D3]   = 4'd7;
    @(negedge Clk);
    n_cmp++;
    if (mem_stall[D3] !== 1'b0 || wb_enable[D3] !== 1'b1 || mem_read[D3] !== 1'b0) begin
      n_bad++; $display("FAIL pass_flags: got stall %b wb %b mr %b expected 0 1 0",
                        mem_stall[D3], wb_enable[D3], mem_read[D3]);
    end
    n_cmp++;
    if (alu_out[D3] !== 16'h5555 || pc_out[D3] !== 10'h155 || dst_mem[D3] !== 4'd7) begin
      n_bad++; $display("FAIL pass_data: got alu %h pc %h dst %h expected 5555 155 7",
                        alu_out[D3], pc_out[D3], dst_mem[D3]);
    end
    @(posedge Clk);
    #1;
    idle(D3);
  endtask

  task automatic test_reset_mid_access();
    int n; logic [15:0] sh, wh, rd; logic mr;
    run_access(D4, 1'b0, 1'b1, 16'h0030, 16'h1111, n, sh, wh, rd, mr);
    n_cmp++;
    if (n !== 4 || sh !== 16'h0007) begin
      n_bad++; $display("FAIL lat4_store_seq: got n=%0d stall %h expected 4 0007", n, sh);
    end
    // Start a store of 0xDEAD and pull reset during its second cycle.
    mem_w_en[D4] = 1'b1;
    alu_res[D4]  = 16'h0030;
    val_rm[D4]   = 16'hDEAD;
    pc_in[D4]    = 10'h030;
    @(negedge Clk);
    n_cmp++;
    if (mem_stall[D4] !== 1'b1) begin
      n_bad++; $display("FAIL abort_first_cycle_stall: got %b expected 1", mem_stall[D4]);
    end
    @(posedge Clk);
    #1;
    rst = 1'b0;
    @(negedge Clk);
    n_cmp++;
    if (mem_stall[D4] !== 1'b0 || wb_enable[D4] !== 1'b0 || mem_read[D4] !== 1'b0) begin
      n_bad++; $display("FAIL abort_in_reset: got stall %b wb %b mr %b expected 0 0 0",
                        mem_stall[D4], wb_enable[D4], mem_read[D4]);
    end
    @(posedge Clk);
    #1;
    rst = 1'b1;
    idle(D4);
    @(negedge Clk);
    n_cmp++;
    if (mem_stall[D4] !== 1'b0) begin
      n_bad++; $display("FAIL abort_after_reset_stall: got %b expected 0", mem_stall[D4]);
    end
    @(posedge Clk);
    #1;
    run_access(D4, 1'b1, 1'b0, 16'h0030, 16'h0000, n, sh, wh, rd, mr);
    n_cmp++;
    if (n !== 4 || sh !== 16'h0007) begin
      n_bad++; $display("FAIL abort_fresh_access: got n=%0d stall %h expected 4 0007", n, sh);
    end
    n_cmp++;
    if (rd !== 16'h1111) begin
      n_bad++; $display("FAIL abort_no_commit: got %h expected 1111", rd);
    end
    idle(D4);
  endtask

`ifdef MEM_STALL_STATS_EN
  task automatic test_stall_stats();
    int n; logic [15:0] sh, wh, rd; logic mr;
    rst = 1'b0;
    @(posedge Clk);
    #1;
    rst = 1'b1;
    @(negedge Clk);
    n_cmp++;
    if (stall_count[D3] !== 16'd0) begin
      n_bad++; $display("FAIL stats_cleared: got %0d expected 0", stall_count[D3]);
    end
    @(posedge Clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      run_access(D3, 1'b1, 1'b0, 16'h0020, 16'h0000, n, sh, wh, rd, mr);
    end
    idle(D3);
    @(negedge Clk);
    n_cmp++;
    if (stall_count[D3] !== 16'd10) begin
      n_bad++; $display("FAIL stats_five_loads: got %0d expected 10", stall_count[D3]);
    end
    @(posedge Clk);
    #1;
    rst = 1'b0;
    @(posedge Clk);
    #1;
    rst = 1'b1;
    @(negedge Clk);
    n_cmp++;
    if (stall_count[D3] !== 16'd0) begin
      n_bad++; $display("FAIL stats_reset: got %0d expected 0", stall_count[D3]);
    end
    @(posedge Clk);
    #1;
  endtask
`endif

  initial begin
    idle(D1); idle(D3); idle(D4);
    rst = 1'b0;
    test_reset();
    test_lat1_store_load();
    test_alias();
    test_lat3_load();
    test_back_to_back();
    test_read_write();
    test_passthrough();
    test_reset_mid_access();
`ifdef MEM_STALL_STATS_EN
    test_stall_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop in case a wait never returns.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
